ram_clr_sp: RTL



---
 rtl/ram_clr_sp_if.sv | 24 ++
 rtl/ram_clr_sp.sv | 115 +++++++++++
 2 files changed

// File: rtl/ram_clr_sp_if.sv
// rtl/ram_clr_sp_if.sv - request/read-return bundle for the clearable single-port RAM
interface ram_clr_sp_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0] req_wmask;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wmask,
    input  req_ready, rd_valid, rd_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wmask,
    output req_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/ram_clr_sp.sv
// rtl/ram_clr_sp.sv - single-port block RAM with bit-masked writes, selectable read latency and a fill engine
module ram_clr_sp #(
  parameter int                DATA_W  = 16,
  parameter int                ADDR_W  = 8,
  parameter logic [DATA_W-1:0] CLR_VAL = '0,
  parameter bit                OUT_REG = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  ram_clr_sp_if.slave bus,
  input  logic        clr_req,
  output logic        busy
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              accept;
  logic              rd_accept;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_wmask;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;

  // clr_req wins over a pending request so a clear never races an access
  assign bus.req_ready = (state == S_RUN) && !clr_req;
  assign accept        = bus.req_valid && bus.req_ready;
  assign rd_accept     = accept && !bus.req_we;

  // The fill engine and the request port share the one array port
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = bus.req_addr;
    mem_wdata = bus.req_wdata;
    mem_wmask = bus.req_wmask;
    if (state == S_CLEAR) begin
      mem_we    = !rst;
      mem_addr  = cnt;
      mem_wdata = CLR_VAL;
      mem_wmask = '1;
    end else begin
      mem_we = accept && bus.req_we && !rst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_CLEAR;
      cnt   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        S_CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == '1) begin
            state <= S_RUN;
            busy  <= 1'b0;
          end
        end
        S_RUN: begin
          if (clr_req) begin
            state <= S_CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        default: begin
          state <= S_CLEAR;
          cnt   <= '0;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < DATA_W; i++) begin
        if (mem_wmask[i]) mem[mem_addr][i] <= mem_wdata[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_accept;
      if (rd_accept) s1_data <= mem[bus.req_addr];
    end
  end

  generate
    if (OUT_REG) begin : g_out_reg
      always_ff @(posedge clk) begin
        if (rst) begin
          bus.rd_valid <= 1'b0;
          bus.rd_data  <= '0;
        end else begin
          bus.rd_valid <= s1_valid;
          if (s1_valid) bus.rd_data <= s1_data;
        end
      end
    end else begin : g_out_direct
      assign bus.rd_valid = s1_valid;
      assign bus.rd_data  = s1_data;
    end
  endgenerate
endmodule
